// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//
// Shared definitions for the memory request/response protocol: the message
// opcode type, the fixed field widths of a memory message, and a byte-lane
// merge helper used when applying strobed writes to a storage word.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   localparam int p_op_bits   = 1;
   localparam int p_addr_bits = 32;
   localparam int p_strb_bits = 4;
   localparam int p_data_bits = 32;

   typedef enum logic [p_op_bits-1:0] {
      MEM_MSG_READ  = 1'b0,
      MEM_MSG_WRITE = 1'b1
   } t_op;

   // Replace each byte lane of old_word with the matching lane of new_word
   // where the strobe bit for that lane is set.
   function automatic logic [p_data_bits-1:0] byte_merge(
      input logic [p_data_bits-1:0] old_word,
      input logic [p_data_bits-1:0] new_word,
      input logic [p_strb_bits-1:0] strb
   );
      logic [p_data_bits-1:0] merged;
      merged = old_word;
      for (int i = 0; i < p_strb_bits; i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage : mem_responder_pkg

// File: rtl/mem_responder_intf.sv
// -----------------------------------------------------------------------------
// MemIntf
//
// Valid/ready memory protocol bundle. A request channel (client -> server)
// and a response channel (server -> client) carry the same message layout:
//   op, opaque[p_opaq_bits-1:0], addr[31:0], strb[3:0], data[31:0]
// packed MSB-first in that order.
//
// Modports:
//   server : responder end (drives req_rdy, resp_val, resp_msg)
//   client : requester end (drives req_val, req_msg, resp_rdy)
// -----------------------------------------------------------------------------
interface MemIntf
   import mem_responder_pkg::*;
#(
   parameter int p_opaq_bits = 8
);

   typedef struct packed {
      t_op                     op;
      logic [p_opaq_bits-1:0]  opaque;
      logic [p_addr_bits-1:0]  addr;
      logic [p_strb_bits-1:0]  strb;
      logic [p_data_bits-1:0]  data;
   } t_mem_msg;

   logic     req_val;
   logic     req_rdy;
   t_mem_msg req_msg;

   logic     resp_val;
   logic     resp_rdy;
   t_mem_msg resp_msg;

   modport server (
      input  req_val, req_msg, resp_rdy,
      output req_rdy, resp_val, resp_msg
   );

   modport client (
      output req_val, req_msg, resp_rdy,
      input  req_rdy, resp_val, resp_msg
   );

endinterface : MemIntf

// File: rtl/mem_responder_delay_queue.sv
// -----------------------------------------------------------------------------
// mem_responder_delay_queue
//
// Circular in-order queue of p_depth response messages. Every entry carries
// a countdown loaded with p_latency-1 on enqueue; the countdown keeps running
// whether or not the entry is at the head, so an entry stalled behind
// backpressure is sendable the moment it reaches the head. Only the head is
// ever offered, which keeps responses strictly in request order.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enq_val    : producer has a message this cycle
//   enq_rdy    : queue can take a message (registered, count < p_depth)
//   enq_msg    : message to enqueue
//   deq_val    : head entry is valid and its countdown has expired
//   deq_rdy    : consumer takes the head this cycle
//   deq_msg    : head message
// -----------------------------------------------------------------------------
module mem_responder_delay_queue #(
   parameter int p_depth    = 4,
   parameter int p_latency  = 1,
   parameter int p_msg_bits = 77
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enq_val,
   output logic                  enq_rdy,
   input  logic [p_msg_bits-1:0] enq_msg,
   output logic                  deq_val,
   input  logic                  deq_rdy,
   output logic [p_msg_bits-1:0] deq_msg
);

   localparam int p_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int p_cnt_bits = $clog2(p_depth + 1);
   localparam int p_cd_bits  = (p_latency > 1) ? $clog2(p_latency) : 1;

   localparam logic [p_cd_bits-1:0]  p_cd_load  = p_cd_bits'(p_latency - 1);
   localparam logic [p_ptr_bits-1:0] p_last_ptr = p_ptr_bits'(p_depth - 1);
   localparam logic [p_cnt_bits-1:0] p_full_cnt = p_cnt_bits'(p_depth);

   typedef struct packed {
      logic                  val;
      logic [p_cd_bits-1:0]  countdown;
      logic [p_msg_bits-1:0] msg;
   } t_entry;

   t_entry                entries_q [p_depth];
   t_entry                head_entry;
   logic [p_ptr_bits-1:0] head_q;
   logic [p_ptr_bits-1:0] tail_q;
   logic [p_cnt_bits-1:0] count_q;
   logic [p_cnt_bits-1:0] count_nxt;
   logic                  rdy_q;
   logic                  enq_fire;
   logic                  deq_fire;

   // Pointers wrap modulo p_depth, which need not be a power of two.
   function automatic logic [p_ptr_bits-1:0] next_ptr(input logic [p_ptr_bits-1:0] ptr);
      return (ptr == p_last_ptr) ? '0 : ptr + 1'b1;
   endfunction

   assign head_entry = entries_q[head_q];
   assign deq_val    = head_entry.val && (head_entry.countdown == '0);
   assign deq_msg    = head_entry.msg;

   // enq_rdy comes straight from a flop: a dequeue while full frees a slot
   // only from the next cycle, and no deq_rdy/enq_val path reaches it.
   assign enq_rdy  = rdy_q;
   assign enq_fire = enq_val && rdy_q;
   assign deq_fire = deq_val && deq_rdy;

   // NOTE: every signal written in always_comb gets a default first so that
   // no path through the block leaves it unassigned (which would be a latch).
   always_comb begin
      count_nxt = count_q;
      unique case ({enq_fire, deq_fire})
         2'b10:   count_nxt = count_q + 1'b1;
         2'b01:   count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rdy_q   <= 1'b0;
         // Payloads are left alone; clearing the valid bits is what discards
         // in-flight responses.
         for (int i = 0; i < p_depth; i++) begin
            entries_q[i].val       <= 1'b0;
            entries_q[i].countdown <= '0;
         end
      end else begin
         for (int i = 0; i < p_depth; i++) begin
            if (entries_q[i].val && (entries_q[i].countdown != '0)) begin
               entries_q[i].countdown <= entries_q[i].countdown - 1'b1;
            end
         end

         if (deq_fire) begin
            entries_q[head_q].val <= 1'b0;
            head_q                <= next_ptr(head_q);
         end

         // Enqueue and dequeue never address the same slot: a valid head
         // with head == tail means the queue is full, so enq_fire is low.
         if (enq_fire) begin
            entries_q[tail_q].val       <= 1'b1;
            entries_q[tail_q].countdown <= p_cd_load;
            entries_q[tail_q].msg       <= enq_msg;
            tail_q                      <= next_ptr(tail_q);
         end

         count_q <= count_nxt;
         rdy_q   <= (count_nxt < p_full_cnt);
      end
   end

endmodule : mem_responder_delay_queue

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory model behind a valid/ready request/response port.
// Writes apply byte strobes at the accepting clock edge; reads capture the
// word at accept time. Each accepted request produces one response, held in
// an in-order delay queue for at least p_latency cycles before it is offered.
//
// Parameters:
//   p_opaq_bits : opaque field width (must match the MemIntf instance)
//   p_num_words : storage depth in 32-bit words, power of two, >= 2
//   p_latency   : minimum accept-to-response-valid cycles, >= 1
//   p_depth     : outstanding responses held, >= 1
//
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (storage is not cleared)
//   mem : MemIntf server end (req_val/req_rdy/req_msg, resp_val/resp_rdy/resp_msg)
// -----------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int p_opaq_bits = 8,
   parameter int p_num_words = 256,
   parameter int p_latency   = 1,
   parameter int p_depth     = 4
) (
   input logic    clk,
   input logic    rst,
   MemIntf.server mem
);

   localparam int p_idx_bits = $clog2(p_num_words);
   localparam int p_msg_bits = p_op_bits + p_opaq_bits + p_addr_bits
                             + p_strb_bits + p_data_bits;

   logic [p_data_bits-1:0] words_q [p_num_words];

   logic [p_idx_bits-1:0]  idx;
   logic [p_data_bits-1:0] cur_word;
   logic [p_data_bits-1:0] rd_data;
   logic                   accept;
   logic                   q_enq_rdy;
   logic                   q_deq_val;
   logic [p_msg_bits-1:0]  q_enq_msg;
   logic [p_msg_bits-1:0]  q_deq_msg;

   // Byte offset bits and bits above the storage depth are dropped, so the
   // address space wraps over the storage.
   assign idx      = mem.req_msg.addr[p_idx_bits+1:2];
   assign cur_word = words_q[idx];
   assign accept   = mem.req_val && q_enq_rdy;

   // The storage array is written at the accepting edge, so a read accepted
   // on the next cycle already sees the new word.
   // NOTE: storage is deliberately not reset; contents survive rst and a
   // reset loop over a RAM would prevent it from mapping onto memory macros.
   always_ff @(posedge clk) begin
      if (accept && (mem.req_msg.op == MEM_MSG_WRITE)) begin
         words_q[idx] <= byte_merge(cur_word, mem.req_msg.data, mem.req_msg.strb);
      end
   end

   // Writes answer with zero data; reads answer with the word as it stands
   // before this edge (no same-cycle write is possible).
   assign rd_data = (mem.req_msg.op == MEM_MSG_READ) ? cur_word : '0;

   // Field order matches the MemIntf message layout, MSB first.
   assign q_enq_msg = {mem.req_msg.op, mem.req_msg.opaque, mem.req_msg.addr,
                       mem.req_msg.strb, rd_data};

   mem_responder_delay_queue #(
      .p_depth    (p_depth),
      .p_latency  (p_latency),
      .p_msg_bits (p_msg_bits)
   ) u_delay_queue (
      .clk     (clk),
      .rst     (rst),
      .enq_val (mem.req_val),
      .enq_rdy (q_enq_rdy),
      .enq_msg (q_enq_msg),
      .deq_val (q_deq_val),
      .deq_rdy (mem.resp_rdy),
      .deq_msg (q_deq_msg)
   );

   assign mem.req_rdy  = q_enq_rdy;
   assign mem.resp_val = q_deq_val;
   assign mem.resp_msg = q_deq_msg;

endmodule : mem_responder

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter p_opaq_bits, default 8: width of the opaque field in request and response messages.
REQ-002 SHALL have parameter p_num_words, default 256: storage depth in 32-bit words, power of two.
REQ-003 SHALL have parameter p_latency, default 1: minimum cycles from request accept to response valid, at least 1.
REQ-004 SHALL have parameter p_depth, default 4: number of outstanding responses held, at least 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port mem, MemIntf server modport: the responder end of the memory protocol.
REQ-008 SHALL have req_val, input, 1 bit; req_rdy, output, 1 bit; req_msg, input, with fields op, opaque, addr[31:0], strb[3:0], data[31:0].
REQ-009 SHALL have resp_val, output, 1 bit; resp_rdy, input, 1 bit; resp_msg, output, with the same fields as req_msg.

Function
REQ-010 SHALL accept a request in every cycle where req_val and req_rdy are both high; at most one request per cycle.
REQ-011 SHALL form the word index as addr[log2(p_num_words)+1:2]; addr[1:0] ignored; higher address bits ignored, so addresses wrap.
REQ-012 On an accepted MEM_MSG_WRITE, SHALL update byte i of the indexed word from data byte i only where strb[i]=1, at the accepting clock edge.
REQ-013 On an accepted MEM_MSG_READ, SHALL capture the indexed word at accept time; strb is ignored for reads.
REQ-014 A read accepted in the cycle after a write to the same word SHALL return the newly written data; no stale read.
REQ-015 SHALL enqueue one response per accepted request in a circular queue of p_depth entries; head and tail pointers wrap modulo p_depth.
REQ-016 resp_msg SHALL echo op, opaque, addr and strb of its request; data SHALL be the read word for a READ and 32'h0 for a WRITE.
REQ-017 Each entry SHALL hold a countdown loaded with p_latency-1 at enqueue and decremented each cycle while non-zero.
REQ-018 resp_val SHALL be high when the head entry is valid with countdown zero; with p_latency=1 the response is valid the cycle after accept.
REQ-019 Responses SHALL be returned strictly in request order; a younger ready entry never bypasses an older one.
REQ-020 A response is dequeued on resp_val and resp_rdy; resp_msg and resp_val SHALL hold stable while resp_val is high and resp_rdy is low.
REQ-021 req_rdy SHALL equal (count < p_depth) and SHALL be registered-state only; no combinational path from resp_rdy or req_val.
REQ-022 When full, a same-cycle dequeue SHALL NOT admit a request that cycle; req_rdy rises the following cycle.
REQ-023 Simultaneous enqueue and dequeue when not full SHALL leave count unchanged.
REQ-024 Countdowns SHALL continue during backpressure, so stalled entries are immediately sendable once they reach the head.
REQ-025 Sustained throughput SHALL be one request per cycle when p_depth >= p_latency+1 and resp_rdy is held high.

Reset
REQ-026 While rst is high: req_rdy=0, resp_val=0, count=0, pointers=0, all entry valid bits=0.
REQ-027 Reset mid-operation SHALL discard all in-flight responses; no response for a pre-reset request is ever emitted.
REQ-028 Storage contents SHALL NOT be reset; they retain prior values through rst.
REQ-029 In the cycle after rst falls, req_rdy SHALL be 1.

Structure
REQ-030 SHALL use t_op, MEM_MSG_READ and MEM_MSG_WRITE from the existing shared package; no local redefinition.
REQ-031 The queue entry struct (val, countdown, response message) SHALL be local to the module; it is not shared.
REQ-032 The delay queue SHALL be a single sub-module, mem_responder_delay_queue, parameterized by p_depth, p_latency and message width.

Verification
REQ-033 Write addr 0x10, data 0xDEADBEEF, strb 4'hF, then read 0x10 with opaque 0x05 -> read response data 0xDEADBEEF, opaque 0x05, op READ.
REQ-034 Word 0x20 = 0x11223344, write data 0xAABBCCDD with strb 4'b0101, then read -> 0x11BB33DD.
REQ-035 p_latency=3: read accepted at cycle t -> resp_val first high at t+3.
REQ-036 p_depth=4, resp_rdy=0, five back-to-back requests -> four accepted, req_rdy=0; one dequeue -> req_rdy=1 the next cycle; all responses arrive in order.
REQ-037 p_num_words=256: write to addr 0x400 then read addr 0x0 -> same word returned (wrap-around).
REQ-038 Two requests in flight, rst pulsed for one cycle -> resp_val stays 0 after reset until a new request is accepted.
